// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// master drives the request side; slave is the arithmetic unit.
interface serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, op, cin, a, b,
    input  busy, done, result, cout, overflow, zero, negative
  );

  modport slave (
    input  start, op, cin, a, b,
    output busy, done, result, cout, overflow, zero, negative
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first, through one DIGIT-wide adder.
// Result and flags are registered at completion and held until the next completion or reset.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; operands latched on the accept edge
//   S_RUN  | one digit per cycle, NDIG cycles
//   S_DONE | one-cycle done pulse; start ignored
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_addsub_if.slave     bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_addsub: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [DIGIT:0]   sum;
  logic [DIGIT-1:0] dig;
  logic             c_next;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] sr_shift;
  logic             last_dig;

  always_comb begin
    sum      = {1'b0, sa_q[DIGIT-1:0]} + {1'b0, sb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    dig      = sum[DIGIT-1:0];
    c_next   = sum[DIGIT];
    dig_ext  = WIDTH'(dig);
    sr_shift = (sr_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    last_dig = (cnt_q == CW'(NDIG - 1));

    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Subtraction runs as A + ~B + ~borrow_in through the same adder.
          sa_d    = bus.a;
          sb_d    = bus.b ^ {WIDTH{bus.op}};
          c_d     = bus.op ? ~bus.cin : bus.cin;
          sr_d    = '0;
          cnt_d   = '0;
          op_d    = bus.op;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> DIGIT;
        sb_d  = sb_q >> DIGIT;
        sr_d  = sr_shift;
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (last_dig) begin
          // On the top digit the operand sign bits sit at bit DIGIT-1 of sa/sb.
          result_d = sr_shift;
          cout_d   = op_q ? ~c_next : c_next;
          ovf_d    = (sa_q[DIGIT-1] == sb_q[DIGIT-1]) && (dig[DIGIT-1] != sa_q[DIGIT-1]);
          zero_d   = (sr_shift == '0);
          neg_d    = sr_shift[WIDTH-1];
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized and directed bench for serial_addsub (WIDTH=16, DIGIT=4) against an arithmetic model.
module tb_serial_addsub;

  localparam int W    = 16;
  localparam int D    = 4;
  localparam int NDIG = W / D;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract, range checks for the flags.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op, input logic cin);
    exp_t   r;
    longint ua, ub, sa, sb, t, s, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    if (!op) begin
      t = ua + ub + longint'(cin);
      s = sa + sb + longint'(cin);
      r.cout = (t >= (longint'(1) << W));
    end else begin
      t = ua - ub - longint'(cin);
      s = sa - sb - longint'(cin);
      r.cout = (t < 0);
    end
    r.res  = t[W-1:0];
    r.ovf  = (s > smax) || (s < smin);
    r.zero = (r.res == '0);
    r.neg  = r.res[W-1];
    return r;
  endfunction

  // Timing/value model: left counts edges remaining until the unit is idle again.
  int   left = 0;
  exp_t pending = '0;
  exp_t held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left    = 0;
      pending = '0;
      held    = '0;
    end else if (left > 0) begin
      left--;
      if (left == 1) held = pending;
    end else if (bus.start) begin
      pending = model(bus.a, bus.b, bus.op, bus.cin);
      left    = NDIG + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, (left >= 2));
    chk("done", bus.done, (left == 1));
    chk("result", bus.result, held.res);
    chk("flags", {bus.cout, bus.overflow, bus.zero, bus.negative},
        {held.cout, held.ovf, held.zero, held.neg});
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic cin, input bit poke, output exp_t got);
    int  lat;
    bit  seen;
    lat  = -1;
    seen = 0;
    got  = '0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.op = op; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 4 * NDIG + 8; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        lat  = cyc;
        seen = 1;
        got  = '{res: bus.result, cout: bus.cout, ovf: bus.overflow,
                 zero: bus.zero, neg: bus.negative};
        break;
      end
      if (cyc == 0) begin
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.op = 1'($urandom); bus.cin = 1'($urandom);
      end
      if (poke && cyc == 1) begin
        bus.start = 1'b1;
        bus.a = W'($urandom); bus.b = W'($urandom);
      end
      if (poke && cyc == 2) bus.start = 1'b0;
    end
    chk("latency", seen ? lat : -1, NDIG);
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic cin, input logic [W-1:0] er,
                          input logic ec, input logic eo, input logic ez, input logic en);
    exp_t got, m;
    m = model(a, b, op, cin);
    chk({nm, "_model"}, {m.res, m.cout, m.ovf, m.zero, m.neg}, {er, ec, eo, ez, en});
    issue(a, b, op, cin, 1'b0, got);
    chk({nm, "_res"}, got.res, er);
    chk({nm, "_flags"}, {got.cout, got.ovf, got.zero, got.neg}, {ec, eo, ez, en});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t got;
    int   extra;
    bus.start = 1'b0; bus.op = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.cout, bus.overflow,
        bus.zero, bus.negative}, '0);
    #2 rst_n = 1'b1;

    directed("add",      16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    directed("sub_zero", 16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    directed("carry",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("sub_cin",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b0);

    // start pulsed during RUN must not queue a second operation
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, got);
    chk("poke_res", got.res, 16'h3333);
    extra = 0;
    for (int i = 0; i < NDIG + 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    chk("no_queue", extra, 0);

    // reset in the middle of RUN
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1111; bus.op = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset", {bus.busy, bus.done, bus.result, bus.cout, bus.overflow,
           bus.zero, bus.negative}, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    directed("after_rst", 16'h4321, 16'h1111, 1'b1, 1'b0, 16'h3210, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        2: ra = 16'h7FFF;
        3: rb = ra;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
